// File: rtl/ov7670_stream_pkg.sv
// ov7670_stream_pkg
// Shared definitions for the OV7670 camera emulator: FSM state codes,
// pattern-select codes, the colour-bar palette and the latched pattern
// configuration record.
package ov7670_stream_pkg;

    // Framing FSM state codes.
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_VSYNC  = 3'd1;
    localparam logic [2:0] ST_VBACK  = 3'd2;
    localparam logic [2:0] ST_ACTIVE = 3'd3;
    localparam logic [2:0] ST_HBLANK = 3'd4;
    localparam logic [2:0] ST_VFRONT = 3'd5;

    // Pattern-select codes seen on pattern_sel.
    localparam logic [1:0] PAT_SOLID    = 2'd0;
    localparam logic [1:0] PAT_BARS     = 2'd1;
    localparam logic [1:0] PAT_GRADIENT = 2'd2;
    localparam logic [1:0] PAT_ADDR     = 2'd3;

    // Colour bars, left to right: element 0 is the leftmost bar.
    localparam logic [7:0][15:0] BAR_COLORS = {
        16'h0000, 16'h001F, 16'hF800, 16'hF81F,
        16'h07E0, 16'h07FF, 16'hFFE0, 16'hFFFF
    };

    // Pattern inputs captured at the start of each frame.
    typedef struct packed {
        logic [1:0]  sel;
        logic [15:0] solid;
    } pattern_cfg_t;

    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        return BAR_COLORS[idx];
    endfunction

endpackage

// File: rtl/ov7670_pattern_gen.sv
// ov7670_pattern_gen
// Combinational RGB565 pixel for the current raster position. The bar
// index arrives pre-computed from a counter in the top, so no divider is
// needed here. x_scroll_lo is the low part of the (possibly scrolled) x
// used by the gradient; frame is the scroll offset (zero when scrolling is
// not built in).
module ov7670_pattern_gen
    import ov7670_stream_pkg::*;
#(
    parameter int IMG_WIDTH = 160
) (
    input  logic [15:0] x,
    input  logic [4:0]  x_scroll_lo,
    input  logic [15:0] y,
    input  logic [2:0]  bar,
    input  logic [1:0]  sel,
    input  logic [15:0] solid,
    input  logic [15:0] frame,
    output logic [15:0] pixel
);

    logic [15:0] addr;

    // Address pattern: frame_buffer write address of this pixel, plus scroll offset, mod 2^16.
    always_comb begin
        addr = y * 16'(IMG_WIDTH) + x + frame;
    end

    // Select the pixel value for the latched pattern.
    always_comb begin
        pixel = 16'h0000;
        case (sel)
            PAT_SOLID:    pixel = solid;
            PAT_BARS:     pixel = bar_color(bar);
            PAT_GRADIENT: pixel = {x_scroll_lo, y[5:0], x_scroll_lo};
            PAT_ADDR:     pixel = addr;
            default:      pixel = 16'h0000;
        endcase
    end

endmodule

// File: rtl/ov7670_stream_gen.sv
// ov7670_stream_gen
// OV7670 camera emulator: drives pclk/vsync/href/data framing from the
// system clock with RGB565 test patterns, so the capture path can be
// exercised without a sensor.
//
// Bus protocol: cam_href is a valid-only qualifier for cam_data; there is
// no backpressure. Every framing output changes only on the clk where
// cam_pclk goes 1->0, so a receiver sampling on rising cam_pclk always sees
// values that have been stable for one clk. cam_data is 0 whenever
// cam_href is 0. Each pixel is sent high byte first.
//
// Build option: define STREAM_GEN_SCROLL_EN to add a per-frame counter f
// that scrolls patterns 1 and 2 by one pixel per frame and offsets
// pattern 3 by f. Framing is identical either way.
//
// VS_LINES, V_BACK and V_FRONT are taken to be at least 1; IMG_WIDTH must
// be a multiple of 8 and H_BLANK at least 1.
module ov7670_stream_gen
    import ov7670_stream_pkg::*;
#(
    parameter int IMG_WIDTH  = 160,
    parameter int IMG_HEIGHT = 120,
    parameter int H_BLANK    = 16,
    parameter int VS_LINES   = 3,
    parameter int V_BACK     = 2,
    parameter int V_FRONT    = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    input  logic [15:0] solid_rgb,
    output logic        cam_pclk,
    output logic        cam_vsync,
    output logic        cam_href,
    output logic [7:0]  cam_data,
    output logic        busy,
    output logic        frame_done,
    output logic [2:0]  dbg_state
);

    localparam int LINE_T = 2 * IMG_WIDTH + H_BLANK;
    localparam int BAR_W  = IMG_WIDTH / 8;

    localparam logic [15:0] VS_LAST  = 16'(VS_LINES * LINE_T - 1);
    localparam logic [15:0] VB_LAST  = 16'(V_BACK * LINE_T - 1);
    localparam logic [15:0] VF_LAST  = 16'(V_FRONT * LINE_T - 1);
    localparam logic [15:0] HB_LAST  = 16'(H_BLANK - 1);
    localparam logic [15:0] X_LAST   = 16'(IMG_WIDTH - 1);
    localparam logic [15:0] Y_LAST   = 16'(IMG_HEIGHT - 1);
    localparam logic [15:0] BAR_LAST = 16'(BAR_W - 1);

    logic [2:0]   state;
    logic [15:0]  cnt;        // pclk count within VSYNC/VBACK/HBLANK/VFRONT
    logic [15:0]  x;          // unscrolled pixel index within the line
    logic [15:0]  xs;         // scrolled pixel index x' for bars/gradient
    logic [15:0]  y;
    logic [15:0]  bar_cnt;    // pixel position of x' inside its bar
    logic [2:0]   bar;        // bar index of x'
    logic         byte_lo;    // 0: high byte on the bus, 1: low byte
    pattern_cfg_t cfg;

    logic         fall;
    logic         frame_end;
    logic [15:0]  pixel;

    logic [15:0]  frame_cnt;
    logic [15:0]  scroll_x;
    logic [15:0]  scroll_bar_cnt;
    logic [2:0]   scroll_bar;

    assign fall      = cam_pclk;
    assign frame_end = fall && (state == ST_VFRONT) && (cnt == VF_LAST);

    // Emulated pixel clock: divide-by-two of clk, starting low out of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cam_pclk <= 1'b0;
        end else begin
            cam_pclk <= ~cam_pclk;
        end
    end

`ifdef STREAM_GEN_SCROLL_EN
    // Scroll origin: frame counter and the bar position of x' = f mod IMG_WIDTH, stepped each frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt      <= 16'd0;
            scroll_x       <= 16'd0;
            scroll_bar_cnt <= 16'd0;
            scroll_bar     <= 3'd0;
        end else if (frame_end) begin
            frame_cnt <= frame_cnt + 16'd1;
            if (scroll_x == X_LAST) begin
                scroll_x       <= 16'd0;
                scroll_bar_cnt <= 16'd0;
                scroll_bar     <= 3'd0;
            end else begin
                scroll_x <= scroll_x + 16'd1;
                if (scroll_bar_cnt == BAR_LAST) begin
                    scroll_bar_cnt <= 16'd0;
                    scroll_bar     <= scroll_bar + 3'd1;
                end else begin
                    scroll_bar_cnt <= scroll_bar_cnt + 16'd1;
                end
            end
        end
    end
`else
    assign frame_cnt      = 16'd0;
    assign scroll_x       = 16'd0;
    assign scroll_bar_cnt = 16'd0;
    assign scroll_bar     = 3'd0;
`endif

    // Framing FSM, raster counters and byte serializer; advances only on pclk fall edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= 16'd0;
            x       <= 16'd0;
            xs      <= 16'd0;
            y       <= 16'd0;
            bar_cnt <= 16'd0;
            bar     <= 3'd0;
            byte_lo <= 1'b0;
            cfg     <= '0;
        end else if (fall) begin
            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        state     <= ST_VSYNC;
                        cnt       <= 16'd0;
                        cfg.sel   <= pattern_sel;
                        cfg.solid <= solid_rgb;
                    end
                end

                ST_VSYNC: begin
                    if (cnt == VS_LAST) begin
                        state <= ST_VBACK;
                        cnt   <= 16'd0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end

                ST_VBACK: begin
                    if (cnt == VB_LAST) begin
                        state   <= ST_ACTIVE;
                        cnt     <= 16'd0;
                        y       <= 16'd0;
                        x       <= 16'd0;
                        xs      <= scroll_x;
                        bar     <= scroll_bar;
                        bar_cnt <= scroll_bar_cnt;
                        byte_lo <= 1'b0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end

                ST_ACTIVE: begin
                    byte_lo <= ~byte_lo;
                    if (byte_lo) begin
                        // Low byte done: step to the next pixel.
                        x <= x + 16'd1;
                        if (xs == X_LAST) begin
                            xs      <= 16'd0;
                            bar     <= 3'd0;
                            bar_cnt <= 16'd0;
                        end else begin
                            xs <= xs + 16'd1;
                            if (bar_cnt == BAR_LAST) begin
                                bar_cnt <= 16'd0;
                                bar     <= bar + 3'd1;
                            end else begin
                                bar_cnt <= bar_cnt + 16'd1;
                            end
                        end
                        if (x == X_LAST) begin
                            state <= ST_HBLANK;
                            cnt   <= 16'd0;
                        end
                    end
                end

                ST_HBLANK: begin
                    if (cnt == HB_LAST) begin
                        cnt <= 16'd0;
                        y   <= y + 16'd1;
                        if (y == Y_LAST) begin
                            state <= ST_VFRONT;
                        end else begin
                            state   <= ST_ACTIVE;
                            x       <= 16'd0;
                            xs      <= scroll_x;
                            bar     <= scroll_bar;
                            bar_cnt <= scroll_bar_cnt;
                            byte_lo <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end

                ST_VFRONT: begin
                    if (cnt == VF_LAST) begin
                        cnt <= 16'd0;
                        x   <= 16'd0;
                        y   <= 16'd0;
                        if (enable) begin
                            state     <= ST_VSYNC;
                            cfg.sel   <= pattern_sel;
                            cfg.solid <= solid_rgb;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    cnt   <= 16'd0;
                end
            endcase
        end
    end

    // End-of-frame strobe, one clk wide, aligned with the closing fall edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_end;
        end
    end

    ov7670_pattern_gen #(
        .IMG_WIDTH (IMG_WIDTH)
    ) u_pattern (
        .x           (x),
        .x_scroll_lo (xs[4:0]),
        .y           (y),
        .bar         (bar),
        .sel         (cfg.sel),
        .solid       (cfg.solid),
        .frame       (frame_cnt),
        .pixel       (pixel)
    );

    assign cam_vsync = (state == ST_VSYNC);
    assign cam_href  = (state == ST_ACTIVE);
    assign busy      = (state != ST_IDLE);
    assign cam_data  = cam_href ? (byte_lo ? pixel[7:0] : pixel[15:8]) : 8'h00;
    assign dbg_state = state;

endmodule

// File: tb/tb_ov7670_stream_gen.sv
// tb_ov7670_stream_gen
// Randomised bench for ov7670_stream_gen on a reduced frame geometry. A
// receiver samples once per pclk period while cam_pclk is high and checks
// every byte against a pixel model computed from the pattern definitions,
// plus line/frame/vsync timing, frame_done, busy and reset behaviour.
// Compile with STREAM_GEN_SCROLL_EN to match a scrolling build.
module tb_ov7670_stream_gen;

  localparam int W          = 32;
  localparam int H          = 8;
  localparam int HB         = 4;
  localparam int VSL        = 2;
  localparam int VBK        = 1;
  localparam int VFR        = 1;
  localparam int L          = 2 * W + HB;
  localparam int FRAME_PCLK = (VSL + VBK + H + VFR) * L;
  localparam int FRAME_CLK  = 2 * FRAME_PCLK;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [1:0]  pattern_sel;
  logic [15:0] solid_rgb;
  logic        cam_pclk;
  logic        cam_vsync;
  logic        cam_href;
  logic [7:0]  cam_data;
  logic        busy;
  logic        frame_done;
  logic [2:0]  dbg_state;

  always #5 clk = ~clk;

  ov7670_stream_gen #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .H_BLANK    (HB),
    .VS_LINES   (VSL),
    .V_BACK     (VBK),
    .V_FRONT    (VFR)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .pattern_sel (pattern_sel),
    .solid_rgb   (solid_rgb),
    .cam_pclk    (cam_pclk),
    .cam_vsync   (cam_vsync),
    .cam_href    (cam_href),
    .cam_data    (cam_data),
    .busy        (busy),
    .frame_done  (frame_done),
    .dbg_state   (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  logic [15:0] bar_tab [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                               16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  int   mdl_f      = 0;
  int   lines      = 0;
  int   line_len   = 0;
  int   pclk_n     = 0;
  int   last_rise  = 0;
  int   fd_count   = 0;
  int   busy_low   = 0;
  logic vs_prev    = 1'b0;
  logic href_prev  = 1'b0;
  logic fd_prev    = 1'b0;
  logic in_frame   = 1'b0;
  logic back_to_back = 1'b0;
  logic want_more  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference pixel straight from the pattern definitions.
  function automatic logic [15:0] model_pixel(input int x, input int y, input logic [1:0] sel,
                                              input logic [15:0] solid, input int f);
    int xs;
    logic [15:0] xv;
    logic [15:0] yv;
    xs = (x + f) % W;
    xv = 16'(xs);
    yv = 16'(y);
    case (sel)
      2'd0:    return solid;
      2'd1:    return bar_tab[xs / (W / 8)];
      2'd2:    return {xv[4:0], yv[5:0], xv[4:0]};
      default: return 16'(y * W + x + f);
    endcase
  endfunction

  task automatic build_frame();
    logic [15:0] p;
    exp_q.delete();
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        p = model_pixel(x, y, pattern_sel, solid_rgb, mdl_f);
        exp_q.push_back(p[15:8]);
        exp_q.push_back(p[7:0]);
      end
    end
  endtask

  // Receiver / monitor: frame_done every clk, bus samples once per pclk-high period.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      lines = 0; line_len = 0; busy_low = 0; mdl_f = 0;
      vs_prev = 1'b0; href_prev = 1'b0; fd_prev = 1'b0;
      in_frame = 1'b0; back_to_back = 1'b0;
    end else begin
      if (fd_prev) check("frame_done_width", {31'd0, frame_done}, 0);
      fd_prev = frame_done;
      if (frame_done) begin
        fd_count++;
        check("frame_lines", lines, H);
        check("frame_bytes_left", exp_q.size(), 0);
        check("busy_at_done", {31'd0, busy}, {31'd0, want_more});
        check("busy_drops", busy_low, 0);
        back_to_back = want_more;
        in_frame = 1'b0;
        lines = 0;
        busy_low = 0;
`ifdef STREAM_GEN_SCROLL_EN
        mdl_f++;
`endif
      end
      if (cam_pclk) begin
        pclk_n++;
        if (in_frame && !busy) busy_low++;
        if (cam_vsync && !vs_prev) begin
          if (back_to_back) check("vsync_period", pclk_n - last_rise, FRAME_PCLK);
          back_to_back = 1'b0;
          last_rise = pclk_n;
          in_frame = 1'b1;
          lines = 0;
          line_len = 0;
          build_frame();
        end
        if (!cam_vsync && vs_prev) check("vsync_width", pclk_n - last_rise, VSL * L);
        if (cam_href) begin
          if (exp_q.size() == 0) check("extra_byte", 1, 0);
          else check($sformatf("y%0d_b%0d", lines, line_len), {24'd0, cam_data}, {24'd0, exp_q.pop_front()});
          line_len++;
        end else begin
          check("blank_data", {24'd0, cam_data}, 0);
          if (href_prev) begin
            check("line_len", line_len, 2 * W);
            lines++;
            line_len = 0;
          end
        end
        vs_prev = cam_vsync;
        href_prev = cam_href;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_vsync(output int lat);
    lat = 0;
    while (!cam_vsync && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    check("vsync_seen", {31'd0, cam_vsync}, 1);
  endtask

  task automatic wait_frame_done();
    int start;
    int n;
    start = fd_count;
    n = 0;
    while (fd_count == start && n < FRAME_CLK + 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("frame_done_seen", fd_count - start, 1);
  endtask

  task automatic wait_line(input int target);
    int n;
    n = 0;
    while (!(lines == target && cam_href) && n < FRAME_CLK) begin
      @(posedge clk); #1;
      n++;
    end
    check("reached_line", lines, target);
  endtask

  task automatic run_single(input logic [1:0] sel, input logic [15:0] solid);
    int lat;
    pattern_sel = sel;
    solid_rgb   = solid;
    want_more   = 1'b0;
    enable      = 1'b1;
    wait_vsync(lat);
    check("enable_latency", {31'd0, (lat >= 1 && lat <= 2)}, 1);
    tick(4);
    enable      = 1'b0;
    pattern_sel = 2'($urandom);       // must not disturb the latched frame
    solid_rgb   = 16'($urandom);
    wait_frame_done();
    tick(6);
    check("idle_busy", {31'd0, busy}, 0);
    check("idle_vsync", {31'd0, cam_vsync}, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pclk"},  {31'd0, cam_pclk}, 0);
    check({tag, "_vsync"}, {31'd0, cam_vsync}, 0);
    check({tag, "_href"},  {31'd0, cam_href}, 0);
    check({tag, "_data"},  {24'd0, cam_data}, 0);
    check({tag, "_busy"},  {31'd0, busy}, 0);
    check({tag, "_fdone"}, {31'd0, frame_done}, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    reset = 1'b1; enable = 1'b0; pattern_sel = 2'd0; solid_rgb = 16'd0;
    tick(3);
    check_all_zero("reset");
    reset = 1'b0;
    tick(1);
    check("pclk_rise", {31'd0, cam_pclk}, 1);
    tick(1);
    check("pclk_fall", {31'd0, cam_pclk}, 0);
    tick(1 + 2 * int'($urandom_range(0, 3)));

    // One frame of each pattern, then two fully random ones.
    for (int s = 0; s < 4; s++) run_single(2'(s), 16'($urandom));
    for (int i = 0; i < 2; i++) run_single(2'($urandom_range(0, 3)), 16'($urandom));

    // Continuous enable for three frames with a new pattern each frame.
    pattern_sel = 2'($urandom_range(0, 3));
    solid_rgb   = 16'($urandom);
    want_more   = 1'b1;
    enable      = 1'b1;
    wait_vsync(lat);
    check("enable_latency_cont", {31'd0, (lat >= 1 && lat <= 2)}, 1);
    for (int i = 0; i < 3; i++) begin
      tick(4);
      pattern_sel = 2'($urandom_range(0, 3));
      solid_rgb   = 16'($urandom);
      if (i == 2) begin
        enable    = 1'b0;
        want_more = 1'b0;
      end
      wait_frame_done();
    end
    tick(6);
    check("cont_idle_busy", {31'd0, busy}, 0);

    // Drop enable halfway down the frame: the frame must still complete.
    pattern_sel = 2'd1;
    solid_rgb   = 16'($urandom);
    want_more   = 1'b0;
    enable      = 1'b1;
    wait_vsync(lat);
    wait_line(H / 2);
    enable = 1'b0;
    wait_frame_done();
    tick(4);
    check("drop_idle_busy", {31'd0, busy}, 0);

    // Reset for one clk in the middle of a line, then a clean frame.
    pattern_sel = 2'd3;
    enable      = 1'b1;
    wait_vsync(lat);
    tick(2);
    enable = 1'b0;
    wait_line(3);
    tick(5 + int'($urandom_range(0, 6)));
    reset = 1'b1;
    tick(1);
    check_all_zero("midreset");
    reset = 1'b0;
    tick(1);
    check("midreset_pclk", {31'd0, cam_pclk}, 1);
    run_single(2'd3, 16'($urandom));
    run_single(2'd2, 16'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time limit in case a bounded wait is somehow bypassed.
  initial begin
    #(2_000_000);
    $display("FAIL watchdog: observed timeout, expected completion");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

endmodule
